// File: rtl/mem_ctrl.sv
// mem_ctrl: 32-bit request port to a 16-bit asynchronous SRAM.
// A byte or half access takes one SRAM beat. A word access takes two beats,
// low half first. Each beat holds the strobes for WAIT+1 cycles.
module mem_ctrl #(
    parameter int ADDR_W = 18,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic              fetch,
    input  logic [1:0]        mem_sz,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    // Accepted request. Address bits above the SRAM window are never stored.
    typedef struct packed {
        logic              wr;
        logic [1:0]        sz;
        logic [ADDR_W:0]   addr;
        logic [31:0]       wdata;
    } req_t;

    localparam logic [2:0] WAIT_C = 3'(WAIT);

    state_t     state;
    logic [2:0] cnt;
    req_t       req;
    logic [15:0] lo_hold;   // low half of a word read, kept until beat 1 ends

    // Upper byte-address bits fall outside the SRAM and are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:ADDR_W+1];

    assign mem_busy = (state != IDLE);

    // Halfword address for a beat. Sub-size address bits are ignored, so
    // misaligned half and word accesses are silently aligned down.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W:0] a,
                                                    input logic [1:0] sz,
                                                    input logic beat);
        if (sz[1]) return {a[ADDR_W:2], beat};
        return a[ADDR_W:1];
    endfunction

    // Data driven onto the SRAM bus for a beat. A byte goes out on both
    // halves, and the lane strobes pick which half the SRAM takes.
    function automatic logic [15:0] beat_data(input logic [31:0] w,
                                              input logic [1:0] sz,
                                              input logic beat);
        case (sz)
            2'd0:    return {w[7:0], w[7:0]};
            2'd1:    return w[15:0];
            default: return beat ? w[31:16] : w[15:0];
        endcase
    endfunction

    // Lane strobes {ub_n, lb_n}. An even byte address selects the low lane.
    function automatic logic [1:0] lane_n(input logic [1:0] sz, input logic a0);
        if (sz == 2'd0) return a0 ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    // Zero-extended read result, built at the end of the last beat.
    function automatic logic [31:0] rd_result(input logic [1:0] sz, input logic a0,
                                              input logic [15:0] rd,
                                              input logic [15:0] lo);
        case (sz)
            2'd0:    return {24'h0, (a0 ? rd[15:8] : rd[7:0])};
            2'd1:    return {16'h0, rd};
            default: return {rd, lo};
        endcase
    endfunction

    // Sequencer: accept a request in IDLE, then step through the beats.
    // The strobes, address and data outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            req        <= '0;
            lo_hold    <= 16'h0;
            mem_rdata  <= 32'h0;
            sram_addr  <= '0;
            sram_wdata <= 16'h0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_r || mem_w || fetch) begin
                        // A write wins over a read or fetch in the same cycle.
                        req.wr    <= mem_w;
                        req.sz    <= mem_sz;
                        req.addr  <= mem_addr[ADDR_W:0];
                        req.wdata <= mem_wdata;
                        state     <= BEAT0;
                        cnt       <= WAIT_C;
                        sram_addr <= beat_addr(mem_addr[ADDR_W:0], mem_sz, 1'b0);
                        if (mem_w) sram_wdata <= beat_data(mem_wdata, mem_sz, 1'b0);
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= mem_w;
                        sram_we_n <= !mem_w;
                        {sram_ub_n, sram_lb_n} <= lane_n(mem_sz, mem_addr[0]);
                    end
                end
                BEAT0, BEAT1: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else if (state == BEAT0 && req.sz[1]) begin
                        // A word goes straight into its second beat. The
                        // strobes stay asserted, so there is no gap cycle.
                        state     <= BEAT1;
                        cnt       <= WAIT_C;
                        sram_addr <= beat_addr(req.addr, req.sz, 1'b1);
                        if (req.wr) sram_wdata <= beat_data(req.wdata, req.sz, 1'b1);
                        if (!req.wr) lo_hold <= sram_rdata;
                    end else begin
                        state     <= IDLE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        if (!req.wr)
                            mem_rdata <= rd_result(req.sz, req.addr[0], sram_rdata, lo_hold);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl. A byte-level reference memory predicts every access.
// A behavioural SRAM sits on the pin side. A monitor checks strobes and the
// address on every busy cycle, and checks the busy length and read data when
// each access completes.
module tb_mem_ctrl;

    localparam int ADDR_W = 18;
    localparam int W      = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              mem_r = 1'b0, mem_w = 1'b0, fetch = 1'b0;
    logic [1:0]        mem_sz = 2'd0;
    logic [31:0]       mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [31:0]       mem_rdata;
    logic              mem_busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wdata, sram_rdata;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    mem_ctrl #(.ADDR_W(ADDR_W), .WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n), .mem_r(mem_r), .mem_w(mem_w), .fetch(fetch),
        .mem_sz(mem_sz), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reset-independent initial SRAM image. Halfword 9 holds 0xDEAD.
    function automatic logic [15:0] init_val(input int i);
        if (i == 9) return 16'hDEAD;
        return 16'(i * 40503 ^ 23130);
    endfunction

    // Behavioural SRAM: 1024 halfwords, reads are combinational, and writes
    // land per lane while ce_n and we_n are low.
    logic [15:0] sram [0:1023];
    bit sram_ready;
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[9:0]] : 16'h0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
            sram_ready <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram[sram_addr[9:0]][7:0]  <= sram_wdata[7:0];
            if (!sram_ub_n) sram[sram_addr[9:0]][15:8] <= sram_wdata[15:8];
        end
    end

    // Reference memory: little-endian bytes covering the same 2 KiB window.
    logic [7:0] ref_mem [0:2047];
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        bit          rd;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          busy;
    } exp_t;
    exp_t q[$];

    // Issue one request in the first idle cycle, then predict its outcome.
    task automatic issue(input bit r, input bit w, input bit f, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int n = 0;
        int a, b;
        @(negedge clk);
        while (mem_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mem_busy) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: busy still 1, required 0");
            return;
        end
        mem_r = r; mem_w = w; fetch = f;
        mem_sz = sz; mem_addr = addr; mem_wdata = wd;
        a = int'(addr[10:0]);
        b = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~1) : (a & ~3);
        e.rd = !w; e.sz = sz; e.addr = addr; e.wd = wd;
        if (e.rd) begin
            case (sz)
                2'd0:    last_rd = {24'h0, ref_mem[a]};
                2'd1:    last_rd = {16'h0, ref_mem[b+1], ref_mem[b]};
                default: last_rd = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            endcase
        end else begin
            case (sz)
                2'd0: ref_mem[a] = wd[7:0];
                2'd1: begin ref_mem[b] = wd[7:0]; ref_mem[b+1] = wd[15:8]; end
                default: begin
                    ref_mem[b]   = wd[7:0];   ref_mem[b+1] = wd[15:8];
                    ref_mem[b+2] = wd[23:16]; ref_mem[b+3] = wd[31:24];
                end
            endcase
        end
        e.rdata = last_rd;
        e.busy  = (sz < 2) ? (W + 1) : 2 * (W + 1);
        q.push_back(e);
        @(posedge clk);
        #1;
        mem_r = 1'b0; mem_w = 1'b0; fetch = 1'b0;
    endtask

    // Monitor: per-cycle pin checks while busy, then completion checks.
    initial begin
        int cyc = 0;
        exp_t t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0;
                continue;
            end
            if (mem_busy) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_busy: busy 1 with no request outstanding");
                end else begin
                    logic [31:0] ha;
                    logic [15:0] ewd;
                    int beat;
                    t = q[0];
                    beat = cyc / (W + 1);
                    ha = (t.sz < 2) ? (t.addr >> 1) : (((t.addr >> 2) << 1) | 32'(beat));
                    case (t.sz)
                        2'd0:    ewd = {t.wd[7:0], t.wd[7:0]};
                        2'd1:    ewd = t.wd[15:0];
                        default: ewd = beat[0] ? t.wd[31:16] : t.wd[15:0];
                    endcase
                    if (t.rd) ewd = 16'h0;
                    check("beat_pins",
                          {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                           sram_addr, (t.rd ? 16'h0 : sram_wdata)},
                          {1'b0, !t.rd, t.rd, (t.sz == 2'd0 && !t.addr[0]),
                           (t.sz == 2'd0 && t.addr[0]), ha[ADDR_W-1:0], ewd});
                end
                cyc++;
            end else if (cyc != 0) begin
                if (q.size() != 0) begin
                    t = q.pop_front();
                    check("busy_cycles", 64'(cyc), 64'(t.busy));
                    check("mem_rdata", mem_rdata, t.rdata);
                    check("idle_strobes",
                          {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
                end
                cyc = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v = init_val(i);
            ref_mem[2*i]   = v[7:0];
            ref_mem[2*i+1] = v[15:8];
        end

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("reset_ctrl", {mem_busy, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
              6'b011111);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_addr_wdata", {sram_addr, sram_wdata}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: word write/read, byte lanes, half read, write-wins.
        issue(0, 1, 0, 2'd2, 32'h10, 32'hDEADBEEF);
        issue(1, 0, 0, 2'd2, 32'h10, 32'h0);
        issue(1, 0, 0, 2'd0, 32'h13, 32'h0);
        issue(0, 1, 0, 2'd0, 32'h20, 32'h5A);
        issue(1, 0, 0, 2'd1, 32'h20, 32'h0);
        issue(1, 1, 0, 2'd1, 32'h0, 32'h1234);
        issue(0, 0, 1, 2'd3, 32'h12, 32'h0);

        // Reset during the second beat of a word read.
        issue(1, 0, 0, 2'd2, 32'h10, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ctrl", {mem_busy, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
              6'b011111);
        check("abort_rdata", mem_rdata, 32'h0);
        check("abort_addr", 64'(sram_addr), 64'h0);
        q.delete();
        last_rd = 32'h0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(1, 0, 0, 2'd2, 32'h10, 32'h0);

        // Random traffic. Upper address bits alias onto the 2 KiB window.
        for (int k = 0; k < 80; k++) begin
            bit r, w, f;
            r = 1'($urandom); w = 1'($urandom); f = 1'($urandom);
            if (!r && !w && !f) r = 1'b1;
            issue(r, w, f, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        begin
            int n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: %0d accesses outstanding, required 0", q.size());
            end
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
